credit_digit_formatter: RTL and testbench
=========================================

Name: credit_digit_formatter

Overview:
Converts the vending machine's binary credit/price value into four digit codes for the seven-segment multiplexer stage directly downstream. Conversion is sequential shift-add-3 (double-dabble), one bit per clock, behind a request/busy/done handshake. Supports leading-zero blanking and an overflow indication of four dashes. Digit outputs are held stable between updates, so the multiplexer always scans a coherent 4-digit value.

Parameters:
VALUE_W, 14, width of the binary input value.
MAX_VALUE, 9999, largest displayable value; anything above shows the overflow pattern.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
req  input  1  conversion request; accepted on a rising clk edge when busy=0.
value  input  VALUE_W  unsigned binary value, sampled on the accepting edge.
blank_lz  input  1  sampled with value; 1 = blank leading zeros.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when new digits are loaded.
digit1  output  7  least-significant (rightmost) digit code.
digit2  output  7  tens digit code.
digit3  output  7  hundreds digit code.
digit4  output  7  thousands (leftmost) digit code.

Behaviour:
- Digit code set on the 7-bit buses: 0-9 = decimal digit, 10 = BLANK, 11 = DASH. No other codes are ever driven.
- Reset (rst_n=0, asynchronous): state IDLE, busy=0, done=0, digit1..digit4 = BLANK, shift counter=0, internal BCD and shift registers cleared.
- States:
  - IDLE: busy=0. On an edge with req=1, capture value and blank_lz, set ovf = (value > MAX_VALUE), clear the 16-bit BCD accumulator, reset the counter, and go to CONVERT.
  - CONVERT: busy=1. On each edge, apply add-3 to every BCD nibble >= 5, then shift {bcd, shift_reg} left by 1. After VALUE_W shifts (counter = VALUE_W-1 on the last one), go to LOAD.
  - LOAD: busy=1 for this cycle. On the edge that leaves LOAD, write digit1..4 and pulse done=1 for exactly one cycle, clear busy, and return to IDLE.
- Latency: for an accepting edge E0, digits and done change on edge E0+VALUE_W+1 (15 with the default). A new req can be accepted on the edge after done.
- req is ignored while busy=1; it is neither queued nor allowed to corrupt the conversion. value changes during busy have no effect.
- Overflow: if ovf=1, LOAD writes DASH to all four digits and ignores blank_lz. The conversion still runs, so latency is unchanged.
- Leading-zero blanking: with blank_lz=1, zero digits from digit4 downward are replaced by BLANK until the first nonzero digit. digit1 is never blanked, so value 0 displays "   0". With blank_lz=0, all digits are shown.
- Between done pulses, the digit outputs are held constant.
- Reset mid-CONVERT aborts immediately to the reset values. No partial digits are ever presented.
- A value of exactly MAX_VALUE converts normally (9,9,9,9). MAX_VALUE+1 is overflow.

Decomposition:
- Shared package holds:
  - DIGIT_BLANK = 7'd10 and DIGIT_DASH = 7'd11, which the BCD2SEVEN_SEGMENT decoder must also honour.
  - The digit code width (7).
  - The state encoding (IDLE, CONVERT, LOAD).
- One natural sub-module, bcd_add3_nibble: a combinational 4-bit "add 3 if >= 5" cell, instantiated four times in the CONVERT datapath.
- Blanking logic and the FSM stay in the top module.

Test Plan:
- Reset, then idle: digit1..4 = 10,10,10,10; busy=0; done=0.
- req with value=1234, blank_lz=0: busy rises after the accepting edge; done pulses exactly 15 edges later; digit4..1 = 1,2,3,4.
- req with value=7, blank_lz=1: digit4..1 = 10,10,10,7. Repeat with value=0: digit4..1 = 10,10,10,0. Repeat with value=0, blank_lz=0: 0,0,0,0.
- req with value=9999 gives 9,9,9,9. Then value=10000 gives 11,11,11,11 with the same 15-cycle latency, also with blank_lz=1.
- Second req with value=5555 asserted mid-conversion of 42 (blank_lz=0): ignored, and the result is 0,0,4,2. A req on the edge after done is accepted.
- rst_n pulsed low at cycle 7 of a conversion of 8888: busy, done and the digits return immediately to their reset values. No done pulse follows, and the display remains all BLANK.

Source files
------------

// File: rtl/credit_digit_formatter_pkg.sv
// Shared definitions for the credit digit formatter and the downstream
// seven-segment decoder: digit code width, special codes and FSM states.
package credit_digit_formatter_pkg;

    // Width of each digit code bus.
    localparam int unsigned DIGIT_W = 7;

    // Codes 0-9 are decimal digits; these two are the only other codes driven.
    localparam logic [DIGIT_W-1:0] DIGIT_BLANK = 7'd10;
    localparam logic [DIGIT_W-1:0] DIGIT_DASH  = 7'd11;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StConvert = 2'd1,
        StLoad    = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_add3_nibble.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_add3_nibble (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Conditional add-3 on one nibble.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/credit_digit_formatter.sv
// Sequential binary-to-BCD converter for the vending machine credit display.
// One bit per clock via shift-add-3, with leading-zero blanking and a
// four-dash overflow pattern. Digit outputs only change on the done pulse.
module credit_digit_formatter
    import credit_digit_formatter_pkg::*;
#(
    parameter int unsigned VALUE_W   = 14,
    parameter int unsigned MAX_VALUE = 9999
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic [VALUE_W-1:0] value,
    input  logic               blank_lz,
    output logic               busy,
    output logic               done,
    output logic [DIGIT_W-1:0] digit1,
    output logic [DIGIT_W-1:0] digit2,
    output logic [DIGIT_W-1:0] digit3,
    output logic [DIGIT_W-1:0] digit4
);

    localparam int unsigned        CntW    = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam logic [CntW-1:0]    CntLast = CntW'(VALUE_W - 1);
    localparam logic [VALUE_W-1:0] MaxVal  = VALUE_W'(MAX_VALUE);

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic [VALUE_W-1:0] shift_q;
    logic [15:0]        bcd_q;
    logic               ovf_q;
    logic               blank_q;

    logic [15:0]        bcd_adj;
    logic [DIGIT_W-1:0] nxt1, nxt2, nxt3, nxt4;

    // Add-3 correction on all four decades ahead of each shift.
    for (genvar i = 0; i < 4; i++) begin : g_add3
        bcd_add3_nibble u_add3 (
            .din  (bcd_q[4*i +: 4]),
            .dout (bcd_adj[4*i +: 4])
        );
    end

    // Final digit codes from the finished BCD value: overflow dashes, else
    // blank zero digits from the left, never touching the units digit.
    always_comb begin
        nxt1 = DIGIT_W'(bcd_q[3:0]);
        nxt2 = DIGIT_W'(bcd_q[7:4]);
        nxt3 = DIGIT_W'(bcd_q[11:8]);
        nxt4 = DIGIT_W'(bcd_q[15:12]);
        if (ovf_q) begin
            nxt1 = DIGIT_DASH;
            nxt2 = DIGIT_DASH;
            nxt3 = DIGIT_DASH;
            nxt4 = DIGIT_DASH;
        end else if (blank_q) begin
            if (bcd_q[15:12] == 4'd0) begin
                nxt4 = DIGIT_BLANK;
                if (bcd_q[11:8] == 4'd0) begin
                    nxt3 = DIGIT_BLANK;
                    if (bcd_q[7:4] == 4'd0) begin
                        nxt2 = DIGIT_BLANK;
                    end
                end
            end
        end
    end

    // Control FSM, conversion datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            blank_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            digit1  <= DIGIT_BLANK;
            digit2  <= DIGIT_BLANK;
            digit3  <= DIGIT_BLANK;
            digit4  <= DIGIT_BLANK;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req) begin
                        shift_q <= value;
                        blank_q <= blank_lz;
                        ovf_q   <= (value > MaxVal);
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StConvert;
                    end
                end
                StConvert: begin
                    // Top BCD bit falls off; it only matters on overflow,
                    // where the digits are replaced by dashes anyway.
                    {bcd_q, shift_q} <= {bcd_adj[14:0], shift_q, 1'b0};
                    if (cnt_q == CntLast) begin
                        state_q <= StLoad;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StLoad: begin
                    digit1  <= nxt1;
                    digit2  <= nxt2;
                    digit3  <= nxt3;
                    digit4  <= nxt4;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_credit_digit_formatter.sv
// Directed bench for credit_digit_formatter: latency, blanking, overflow,
// ignored requests during a conversion and asynchronous abort.
module tb_credit_digit_formatter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [13:0] value;
    logic        blank_lz;
    logic        busy;
    logic        done;
    logic [6:0]  digit1, digit2, digit3, digit4;

    int checks = 0;
    int errors = 0;

    credit_digit_formatter #(
        .VALUE_W   (14),
        .MAX_VALUE (9999)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .value    (value),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .digit1   (digit1),
        .digit2   (digit2),
        .digit3   (digit3),
        .digit4   (digit4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_digits(input string tag, input int d4, input int d3, input int d2,
                                input int d1);
        check({tag, "_d4"}, 32'(digit4), d4);
        check({tag, "_d3"}, 32'(digit3), d3);
        check({tag, "_d2"}, 32'(digit2), d2);
        check({tag, "_d1"}, 32'(digit1), d1);
    endtask

    // Present a request; returns #1 after the accepting edge.
    task automatic start_conv(input string tag, input int v, input logic b);
        value    = 14'(v);
        blank_lz = b;
        req      = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        check({tag, "_busy_rise"}, 32'(busy), 1);
        check({tag, "_done_low"}, 32'(done), 0);
    endtask

    // Wait for done, counting edges since the accepting edge.
    task automatic wait_done(input string tag, input int elapsed);
        int edges;
        edges = elapsed;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, "_latency"}, edges, 15);
        check({tag, "_busy_clr"}, 32'(busy), 0);
    endtask

    task automatic conv(input string tag, input int v, input logic b, input int d4,
                        input int d3, input int d2, input int d1);
        start_conv(tag, v, b);
        wait_done(tag, 0);
        check_digits(tag, d4, d3, d2, d1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        rst_n    = 1'b0;
        req      = 1'b0;
        value    = '0;
        blank_lz = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 0);
        check_digits("rst", 10, 10, 10, 10);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);
        check_digits("idle", 10, 10, 10, 10);

        conv("v1234", 1234, 1'b0, 1, 2, 3, 4);
        // done is a single-cycle pulse and the digits stay put afterwards.
        @(posedge clk);
        #1;
        check("v1234_done_pulse", 32'(done), 0);
        check_digits("v1234_hold", 1, 2, 3, 4);
        repeat (3) @(posedge clk);
        #1;
        check_digits("v1234_hold2", 1, 2, 3, 4);

        conv("v7_blank", 7, 1'b1, 10, 10, 10, 7);
        conv("v0_blank", 0, 1'b1, 10, 10, 10, 0);
        conv("v0_noblank", 0, 1'b0, 0, 0, 0, 0);
        conv("v1000_blank", 1000, 1'b1, 1, 0, 0, 0);
        conv("v100_blank", 100, 1'b1, 10, 1, 0, 0);
        conv("v9999", 9999, 1'b0, 9, 9, 9, 9);
        conv("v10000", 10000, 1'b0, 11, 11, 11, 11);
        conv("v10000_blank", 10000, 1'b1, 11, 11, 11, 11);
        conv("v16383", 16383, 1'b0, 11, 11, 11, 11);

        // A request during the conversion of 42 must be ignored.
        start_conv("v42", 42, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        value    = 14'd5555;
        blank_lz = 1'b1;
        req      = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        req = 1'b0;
        check("v42_busy_mid", 32'(busy), 1);
        wait_done("v42", 7);
        check_digits("v42", 0, 0, 4, 2);
        // Request on the edge right after done is accepted.
        conv("v321_b2b", 321, 1'b1, 10, 3, 2, 1);

        // Asynchronous reset at cycle 7 of a conversion of 8888.
        start_conv("v8888", 8888, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check_digits("abort", 10, 10, 10, 10);
        #2;
        rst_n  = 1'b1;
        pulses = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        check("abort_idle_busy", 32'(busy), 0);
        check_digits("abort_after", 10, 10, 10, 10);

        // Formatter still works after the abort.
        conv("v56_after", 56, 1'b0, 0, 0, 5, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
